pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 129 ++++++++++++
 tb/tb_pc_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
//==============================================================================
// Module      : pc_unit
// Description : Program counter register with a BOOT/RUN/HALT sequencer.
//               Next PC is selected with priority Jump > Branch > PC_seq.
//               Stall holds PC. Halt or a misaligned target stops fetch
//               until reset. Misaligned targets also set a sticky flag.
//               Optional macro PC_UNIT_PERF_CNT_EN adds the Fetch_cnt
//               output, a counter of PC loads.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_seq,
    input  logic [31:0] PC_branch,
    input  logic [31:0] PC_jump,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Stall,
    input  logic        Halt,
    output logic [31:0] PC,
    output logic        PC_valid,
    output logic        Misalign
`ifdef PC_UNIT_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_misalign;

    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic        w_load;

    // Next-PC selection: Jump beats Branch, which beats the sequential PC.
    always_comb begin
        w_target            = PC_seq;
        w_target_misaligned = 1'b0;
        w_load              = 1'b0;
        if (Jump) begin
            w_target = PC_jump;
        end else if (Branch) begin
            w_target = PC_branch;
        end
        w_target_misaligned = |w_target[1:0];
        // A load happens only in RUN when nothing blocks it.
        w_load = (r_state == S_RUN) && !Halt && !Stall && !w_target_misaligned;
    end

    // Sequencer and PC register; all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    // One idle cycle at the reset vector before fetching.
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                end
                S_RUN: begin
                    if (Halt) begin
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                    end else if (Stall) begin
                        r_state <= S_RUN;
                    end else if (w_target_misaligned) begin
                        // Refuse the target, keep the old PC, stop fetching.
                        r_state    <= S_HALT;
                        r_valid    <= 1'b0;
                        r_misalign <= 1'b1;
                    end else begin
                        r_pc <= w_target;
                    end
                end
                S_HALT: begin
                    // Terminal until reset; inputs are ignored.
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_HALT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_UNIT_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;

    // Count every PC load; natural 32-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_load) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign Fetch_cnt = r_fetch_cnt;
`else
    logic w_load_unused;
    assign w_load_unused = w_load;
`endif

    assign PC       = r_pc;
    assign PC_valid = r_valid;
    assign Misalign = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit. A behavioural model tracks
//               the expected PC/PC_valid/Misalign (and Fetch_cnt when
//               PC_UNIT_PERF_CNT_EN is defined); a compare process checks
//               the DUT every falling edge. Directed literal checks pin the
//               model to hand-computed values.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC_seq;
    logic [31:0] PC_branch = 32'd0;
    logic [31:0] PC_jump = 32'd0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic        Stall = 1'b0;
    logic        Halt = 1'b0;
    logic [31:0] PC;
    logic        PC_valid;
    logic        Misalign;
`ifdef PC_UNIT_PERF_CNT_EN
    logic [31:0] Fetch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Add stage: sequential PC is the current PC plus four.
    assign PC_seq = PC + 32'd4;

    pc_unit #(.RESET_VECTOR(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC_seq    (PC_seq),
        .PC_branch (PC_branch),
        .PC_jump   (PC_jump),
        .Branch    (Branch),
        .Jump      (Jump),
        .Stall     (Stall),
        .Halt      (Halt),
        .PC        (PC),
        .PC_valid  (PC_valid),
        .Misalign  (Misalign)
`ifdef PC_UNIT_PERF_CNT_EN
        ,
        .Fetch_cnt (Fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_stopped;
    bit          m_mis;
    logic [31:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] t;
        if (!rst_n) begin
            m_pc      <= RV;
            m_booting <= 1'b1;
            m_stopped <= 1'b0;
            m_mis     <= 1'b0;
            m_cnt     <= 32'd0;
        end else if (m_stopped) begin
            m_pc <= m_pc;
        end else if (m_booting) begin
            m_booting <= 1'b0;
        end else if (Halt) begin
            m_stopped <= 1'b1;
        end else if (!Stall) begin
            t = Jump ? PC_jump : (Branch ? PC_branch : PC_seq);
            if ((t % 4) != 0) begin
                m_mis     <= 1'b1;
                m_stopped <= 1'b1;
            end else begin
                m_pc  <= t;
                m_cnt <= m_cnt + 32'd1;
            end
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        chk("cmp_pc", PC, m_pc);
        chk("cmp_valid", {31'd0, PC_valid}, {31'd0, (!m_booting && !m_stopped)});
        chk("cmp_misalign", {31'd0, Misalign}, {31'd0, m_mis});
`ifdef PC_UNIT_PERF_CNT_EN
        chk("cmp_fetch_cnt", Fetch_cnt, m_cnt);
`endif
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", PC, RV);
        chk("rst_valid", {31'd0, PC_valid}, 32'd0);
        chk("rst_mis", {31'd0, Misalign}, 32'd0);

        // Boot sequence.
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("boot_pc", PC, 32'h3000);
        chk("boot_valid", {31'd0, PC_valid}, 32'd0);
        @(negedge clk);
        chk("run0_pc", PC, 32'h3000);
        chk("run0_valid", {31'd0, PC_valid}, 32'd1);
        @(negedge clk);
        chk("seq1_pc", PC, 32'h3004);
        @(negedge clk);
        chk("seq2_pc", PC, 32'h3008);

        // Priority Jump > Branch.
        PC_jump = 32'h40; PC_branch = 32'h80; Jump = 1'b1; Branch = 1'b1;
        @(negedge clk);
        chk("prio_jump", PC, 32'h40);
        Jump = 1'b0;
        @(negedge clk);
        chk("prio_branch", PC, 32'h80);
        Branch = 1'b0;

        // Stall for three cycles with Jump asserted.
        Stall = 1'b1; Jump = 1'b1; PC_jump = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", PC, 32'h80);
            chk("stall_valid", {31'd0, PC_valid}, 32'd1);
`ifdef PC_UNIT_PERF_CNT_EN
            chk("stall_cnt", Fetch_cnt, 32'd4);
`endif
        end
        Stall = 1'b0; Jump = 1'b0;
        @(negedge clk);
        chk("post_stall_pc", PC, 32'h84);

        // Wrap-around of the sequential PC.
        Jump = 1'b1; PC_jump = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_pre_pc", PC, 32'hFFFF_FFFC);
        Jump = 1'b0;
        @(negedge clk);
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_mis", {31'd0, Misalign}, 32'd0);

        // Misaligned branch target.
        Branch = 1'b1; PC_branch = 32'h0000_0102;
        @(negedge clk);
        chk("mis_pc", PC, 32'h0);
        chk("mis_flag", {31'd0, Misalign}, 32'd1);
        chk("mis_valid", {31'd0, PC_valid}, 32'd0);
        Branch = 1'b0; Jump = 1'b1; PC_jump = 32'h40;
        repeat (2) @(negedge clk);
        chk("mis_ignore_pc", PC, 32'h0);
        chk("mis_sticky", {31'd0, Misalign}, 32'd1);

        // Reset pulse clears everything.
        #2 rst_n = 1'b0;
        #1;
        chk("mis_rst_pc", PC, RV);
        chk("mis_rst_flag", {31'd0, Misalign}, 32'd0);
        Jump = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reboot_valid", {31'd0, PC_valid}, 32'd0);
        @(negedge clk);
        chk("rerun_valid", {31'd0, PC_valid}, 32'd1);
        @(negedge clk);
        chk("rerun_pc", PC, 32'h3004);

        // Halt beats Stall and a misaligned Jump.
        Halt = 1'b1; Stall = 1'b1; Jump = 1'b1; PC_jump = 32'h41;
        @(negedge clk);
        chk("halt_pc", PC, 32'h3004);
        chk("halt_valid", {31'd0, PC_valid}, 32'd0);
        chk("halt_mis", {31'd0, Misalign}, 32'd0);
        Halt = 1'b0; Stall = 1'b0; PC_jump = 32'h100;
        repeat (2) @(negedge clk);
        chk("halt_hold_pc", PC, 32'h3004);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", PC, RV);
        chk("async_rst_valid", {31'd0, PC_valid}, 32'd0);
        Jump = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("final_pc", PC, 32'h3008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
